// File: rtl/ready_valid_fifo_deq_gate_if.sv
// Ready-valid stream bundle for ready_valid_fifo_deq_gate: enqueue side (I_*) and dequeue side (O_*).
// The slave modport is the FIFO's view; the master modport is the producer/consumer view.
interface ready_valid_fifo_deq_gate_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] I_data;
  logic             I_valid;
  logic             I_ready;
  logic [WIDTH-1:0] O_data;
  logic             O_valid;
  logic             O_ready;

  modport master (
    output I_data,
    output I_valid,
    input  I_ready,
    input  O_data,
    input  O_valid,
    output O_ready
  );

  modport slave (
    input  I_data,
    input  I_valid,
    output I_ready,
    output O_data,
    output O_valid,
    input  O_ready
  );
endinterface

// File: rtl/ready_valid_fifo_deq_gate.sv
// DEPTH-entry ready-valid FIFO with a hold input that gates dequeue without disturbing contents.
// Define RV_FIFO_BYPASS_EN for a zero-latency combinational pass-through when the FIFO is empty.
module ready_valid_fifo_deq_gate #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  ready_valid_fifo_deq_gate_if.slave   bus,
  input  logic                         hold,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [AW:0]   CntOne = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;

  logic             w_empty;
  logic             w_full;
  logic             w_enq;
  logic             w_deq;
  logic             w_write;
  logic             w_pop;
  logic [AW:0]      w_cnt_nxt;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CntFull);
  assign count   = r_cnt;

  // I_ready looks only at stored state, so a full FIFO never accepts on the cycle it drains.
  assign bus.I_ready = !w_full & !RESET;

`ifdef RV_FIFO_BYPASS_EN
  logic w_bypass;

  assign bus.O_valid = (!w_empty | bus.I_valid) & !hold & !RESET;
  assign bus.O_data  = w_empty ? bus.I_data : r_mem[r_rd_ptr];

  // An empty-FIFO word consumed in the same cycle never touches storage.
  assign w_bypass = w_empty & w_enq & w_deq;
  assign w_write  = w_enq & !w_bypass;
  assign w_pop    = w_deq & !w_bypass;
`else
  assign bus.O_valid = !w_empty & !hold & !RESET;
  assign bus.O_data  = r_mem[r_rd_ptr];

  assign w_write = w_enq;
  assign w_pop   = w_deq;
`endif

  assign w_enq = bus.I_valid & bus.I_ready;
  assign w_deq = bus.O_valid & bus.O_ready;

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_write, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CntOne;
      2'b01:   w_cnt_nxt = r_cnt - CntOne;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + PtrOne;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PtrOne;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (w_write) r_mem[r_wr_ptr] <= bus.I_data;
  end

endmodule

// File: tb/tb_ready_valid_fifo_deq_gate.sv
// Self-checking bench for ready_valid_fifo_deq_gate: directed scenarios plus random traffic,
// all compared each cycle against a queue-based reference model.
module tb_ready_valid_fifo_deq_gate;
  localparam int unsigned WIDTH = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          CLK;
  logic          RESET;
  logic          hold;
  logic [AW:0]   count;

  ready_valid_fifo_deq_gate_if #(.WIDTH(WIDTH)) bus_if ();

  ready_valid_fifo_deq_gate #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if),
    .hold  (hold),
    .count (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] model_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, check outputs, advance the model, cross the
  // rising edge.
  task automatic cycle(input logic rst, input logic iv, input logic [WIDTH-1:0] id,
                       input logic ordy, input logic hld);
    bit exp_irdy;
    bit exp_ovld;
    bit enq;
    bit deq;
    logic [WIDTH-1:0] exp_odata;
    @(negedge CLK);
    RESET          = rst;
    bus_if.I_valid = iv;
    bus_if.I_data  = id;
    bus_if.O_ready = ordy;
    hold           = hld;
    #1;
    exp_irdy = (model_q.size() < DEPTH) && !rst;
`ifdef RV_FIFO_BYPASS_EN
    exp_ovld = ((model_q.size() > 0) || iv) && !hld && !rst;
`else
    exp_ovld = (model_q.size() > 0) && !hld && !rst;
`endif
    exp_odata = (model_q.size() > 0) ? model_q[0] : id;
    check_eq("I_ready", 32'(bus_if.I_ready), 32'(exp_irdy));
    check_eq("O_valid", 32'(bus_if.O_valid), 32'(exp_ovld));
    check_eq("count",   32'(count),          32'(model_q.size()));
    if (exp_ovld) check_eq("O_data", 32'(bus_if.O_data), 32'(exp_odata));
    enq = iv && exp_irdy;
    deq = exp_ovld && ordy;
    if (rst) begin
      model_q.delete();
    end else if (!(model_q.size() == 0 && enq && deq)) begin
      if (deq) void'(model_q.pop_front());
      if (enq) model_q.push_back(id);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET          = 1'b1;
    hold           = 1'b0;
    bus_if.I_valid = 1'b0;
    bus_if.I_data  = '0;
    bus_if.O_ready = 1'b0;
    @(posedge CLK);
    #1;
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_eq("reset_count", 32'(count), 32'd0);

    // Fill to full, fifth word held off
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, WIDTH'(i), 1'b0, 1'b0);
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_irdy",  32'(bus_if.I_ready), 32'd0);

    // Drain in order; 0x05 gets in one cycle after the first dequeue
    for (int i = 0; i < 6; i++) cycle(1'b0, (i < 2), WIDTH'(5), 1'b1, 1'b0);
    check_eq("drain_count", 32'(count), 32'd0);

    // Hold blocks dequeue with two words buffered
    cycle(1'b0, 1'b1, WIDTH'(5'h0A), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, WIDTH'(5'h0B), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("hold_count", 32'(count), 32'd2);
    check_eq("hold_head",  32'(bus_if.O_data), 32'h0A);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Steady stream, pointers wrap several times
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, WIDTH'(i + 7), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Reset mid-operation discards buffered words
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, WIDTH'(i + 20), 1'b0, 1'b0);
    check_eq("prerst_count", 32'(count), 32'd3);
    cycle(1'b1, 1'b1, WIDTH'(5'h1F), 1'b1, 1'b0);
    check_eq("rst_count", 32'(count), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("postrst_irdy", 32'(bus_if.I_ready), 32'd1);

    // Empty FIFO, single word: bypass presents it at once, otherwise a cycle later
    cycle(1'b0, 1'b1, WIDTH'(5'h1A), 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Random traffic with occasional reset and hold
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom), WIDTH'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
